// File: rtl/gauss3x3_stream_filter.sv
// ============================================================================
// Module   : gauss3x3_stream_filter
// Brief    : Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16, round-half-up)
//            over raster-order pixels, emitting interior pixels only.
//            Optional macro GAUSS_BYPASS_EN adds cfg_bypass (centre passthrough).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss3x3_stream_filter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_eof,
    output logic          frame_done
`ifdef GAUSS_BYPASS_EN
    ,
    input  logic          cfg_bypass
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DW + 4;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_lb0 [IMG_W];
    logic [DW-1:0] r_lb1 [IMG_W];
    // Index 0 = left window column, 1 = centre; the right column is the live input.
    logic [DW-1:0] r_top [2];
    logic [DW-1:0] r_mid [2];
    logic [DW-1:0] r_bot [2];

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_emit;
    logic [DW-1:0] w_up1;
    logic [DW-1:0] w_up2;
    logic [SW-1:0] w_sum;
    logic [DW-1:0] w_filt;
    logic [DW-1:0] w_res;

    assign in_ready   = out_ready | ~out_valid;
    assign w_accept   = in_valid & in_ready;
    assign w_col      = in_sof ? '0 : r_col;
    assign w_row      = in_sof ? '0 : r_row;
    assign w_col_last = (w_col == CW'(IMG_W - 1));
    assign w_row_last = (w_row == RW'(IMG_H - 1));
    assign w_emit     = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_up1      = r_lb0[w_col];
    assign w_up2      = r_lb1[w_col];

    assign w_sum = SW'(r_top[0]) + (SW'(r_top[1]) << 1) + SW'(w_up2)
                 + (SW'(r_mid[0]) << 1) + (SW'(r_mid[1]) << 2) + (SW'(w_up1) << 1)
                 + SW'(r_bot[0]) + (SW'(r_bot[1]) << 1) + SW'(in_data);
    assign w_filt = DW'((w_sum + SW'(8)) >> 4);

`ifdef GAUSS_BYPASS_EN
    assign w_res = cfg_bypass ? r_mid[1] : w_filt;
`else
    assign w_res = w_filt;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // Line buffers and window carry data only; their contents need no reset.
    always_ff @(posedge clk_clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_up1;
            r_lb0[w_col] <= in_data;
            r_top[0]     <= r_top[1];
            r_top[1]     <= w_up2;
            r_mid[0]     <= r_mid[1];
            r_mid[1]     <= w_up1;
            r_bot[0]     <= r_bot[1];
            r_bot[1]     <= in_data;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_eof;
            if (w_accept) begin
                out_valid <= w_emit;
                out_eof   <= w_emit & w_row_last & w_col_last;
                if (w_emit) begin
                    out_data <= w_res;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
